spram_arbiter: RTL and testbench

- Shares the single-port SPRAM (ice40up5k_spram) between two bus masters of the FemtoRV32 memory-bus flavour.
  - Master 0: the CPU.
  - Master 1: a DMA/streaming engine.
- Sits between the RAM-decoded slice of the memory bus and the SPRAM instance.
- Uncontended accesses pass with zero added latency. Collisions are resolved by round-robin with single-entry per-master request capture.

---
 rtl/spram_arbiter_pkg.sv | 23 ++
 rtl/spram_arbiter_if.sv | 16 +
 rtl/spram_arbiter_req_slot.sv | 47 ++++
 rtl/spram_arbiter.sv | 139 +++++++++++++
 tb/tb_spram_arbiter.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/spram_arbiter_pkg.sv
// Shared types and constants for the two-master SPRAM arbiter.
package spram_arbiter_pkg;

  localparam int NUM_MASTERS = 2;
  localparam int SPRAM_AW    = 15;
  localparam int SPRAM_DW    = 32;

  // Master 0 is the CPU, master 1 the DMA/streaming engine.
  typedef logic mst_idx_t;

  // One captured bus request; is_read marks a read strobe, otherwise wmask is the write.
  typedef struct packed {
    logic [SPRAM_AW-1:0] addr;
    logic [SPRAM_DW-1:0] wdata;
    logic [3:0]          wmask;
    logic                is_read;
  } req_t;

  function automatic logic req_is_write(input req_t r);
    return !r.is_read && (|r.wmask);
  endfunction

endpackage

// File: rtl/spram_arbiter_if.sv
// FemtoRV32-style memory bus slice for one master of the SPRAM arbiter.
interface spram_arbiter_if #(
  parameter int AW = 15,
  parameter int DW = 32
);
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [3:0]    wmask;
  logic          rstrb;
  logic [DW-1:0] rdata;
  logic          rbusy;
  logic          wbusy;

  modport master (output addr, wdata, wmask, rstrb, input rdata, rbusy, wbusy);
  modport slave  (input addr, wdata, wmask, rstrb, output rdata, rbusy, wbusy);
endinterface

// File: rtl/spram_arbiter_req_slot.sv
// Per-master single-entry capture register: holds a request that lost
// arbitration until it is granted in the following cycle.
module spram_req_slot
  import spram_arbiter_pkg::*;
(
  input  logic clk,
  input  logic resetq,
  input  req_t new_req,
  input  logic capture,      // new request lost this cycle
  input  logic release_pend, // pending request granted this cycle
  output logic pend,
  output req_t preg,
  output logic rbusy,
  output logic wbusy
);

  logic pend_d, pend_q;
  req_t preg_d, preg_q;

  // Next pending state: set on capture, cleared when granted.
  always_comb begin
    pend_d = pend_q;
    preg_d = preg_q;
    if (release_pend) pend_d = 1'b0;
    if (capture) begin
      pend_d = 1'b1;
      preg_d = new_req;
    end
  end

  // Slot registers; reset drops any in-flight pending request.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      pend_q <= 1'b0;
      preg_q <= '0;
    end else begin
      pend_q <= pend_d;
      preg_q <= preg_d;
    end
  end

  assign pend  = pend_q;
  assign preg  = preg_q;
  assign rbusy = pend_q & preg_q.is_read;
  assign wbusy = pend_q & req_is_write(preg_q);

endmodule

// File: rtl/spram_arbiter.sv
// Shares one single-port SPRAM between the CPU (m0) and a DMA engine (m1).
// Uncontended accesses go straight through; collisions are resolved
// round-robin and the loser is replayed from its slot one cycle later.
module spram_arbiter
  import spram_arbiter_pkg::*;
#(
  parameter int AW = SPRAM_AW,
  parameter int DW = SPRAM_DW
) (
  input  logic           clk,
  input  logic           resetq,
  spram_arbiter_if.slave m0,
  spram_arbiter_if.slave m1,
  output logic [AW-1:0]  ram_addr,
  output logic [DW-1:0]  ram_wdata,
  output logic [3:0]     ram_wen,
  input  logic [DW-1:0]  ram_rdata
);

  req_t                   new_req [NUM_MASTERS];
  req_t                   preg    [NUM_MASTERS];
  logic [NUM_MASTERS-1:0] strobe, new_vld, pend, capture, release_pend;
  logic [NUM_MASTERS-1:0] rbusy, wbusy, gnt_mask;

  logic     gnt_vld;
  mst_idx_t gnt;
  req_t     gnt_req;

  logic                           last_d, last_q;
  logic                           rd_valid_d, rd_valid_q;
  mst_idx_t                       rd_owner_d, rd_owner_q;
  logic [NUM_MASTERS-1:0][DW-1:0] rdata_d, rdata_q;
  logic [AW-1:0]                  addr_hold_d, addr_hold_q;
  logic [DW-1:0]                  wdata_hold_d, wdata_hold_q;

  // Port-side requests; a strobe from an already-pending master is ignored.
  always_comb begin
    new_req[0] = '{addr: m0.addr, wdata: m0.wdata, wmask: m0.wmask, is_read: m0.rstrb};
    new_req[1] = '{addr: m1.addr, wdata: m1.wdata, wmask: m1.wmask, is_read: m1.rstrb};
    strobe     = {m1.rstrb | (|m1.wmask), m0.rstrb | (|m0.wmask)};
    new_vld    = strobe & ~pend;
  end

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_slot
    spram_req_slot u_slot (
      .clk          (clk),
      .resetq       (resetq),
      .new_req      (new_req[i]),
      .capture      (capture[i]),
      .release_pend (release_pend[i]),
      .pend         (pend[i]),
      .preg         (preg[i]),
      .rbusy        (rbusy[i]),
      .wbusy        (wbusy[i])
    );
  end

  // Grant: a pending replay beats new requests; a tie goes to the master not served last.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = 1'b0;
    gnt_req = '0;
    if (pend[0]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
      gnt_req = preg[0];
    end else if (pend[1]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
      gnt_req = preg[1];
    end else if (new_vld[0] && new_vld[1]) begin
      gnt_vld = 1'b1;
      gnt     = ~last_q;
      gnt_req = new_req[~last_q];
    end else if (new_vld[0]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b0;
      gnt_req = new_req[0];
    end else if (new_vld[1]) begin
      gnt_vld = 1'b1;
      gnt     = 1'b1;
      gnt_req = new_req[1];
    end
    // No SPRAM access at all while reset is asserted.
    if (!resetq) gnt_vld = 1'b0;
    gnt_mask = '0;
    if (gnt_vld) gnt_mask[gnt] = 1'b1;
    capture      = new_vld & ~gnt_mask;
    release_pend = pend & gnt_mask;
  end

  assign ram_addr  = gnt_vld ? gnt_req.addr  : addr_hold_q;
  assign ram_wdata = gnt_vld ? gnt_req.wdata : wdata_hold_q;
  assign ram_wen   = (gnt_vld && !gnt_req.is_read) ? gnt_req.wmask : 4'b0000;

  // Next state for round-robin pointer, read-return tracking and held read data.
  always_comb begin
    last_d       = gnt_vld ? gnt : last_q;
    rd_valid_d   = gnt_vld & gnt_req.is_read;
    rd_owner_d   = gnt_vld ? gnt : rd_owner_q;
    addr_hold_d  = ram_addr;
    wdata_hold_d = ram_wdata;
    rdata_d      = rdata_q;
    if (rd_valid_q) rdata_d[rd_owner_q] = ram_rdata;
  end

  // Arbiter registers; last resets to 1 so master 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!resetq) begin
      last_q       <= 1'b1;
      rd_valid_q   <= 1'b0;
      rd_owner_q   <= 1'b0;
      rdata_q      <= '0;
      addr_hold_q  <= '0;
      wdata_hold_q <= '0;
    end else begin
      last_q       <= last_d;
      rd_valid_q   <= rd_valid_d;
      rd_owner_q   <= rd_owner_d;
      rdata_q      <= rdata_d;
      addr_hold_q  <= addr_hold_d;
      wdata_hold_q <= wdata_hold_d;
    end
  end

  // Fresh SPRAM data the cycle after the read, held copy afterwards.
  assign m0.rdata = (rd_valid_q && rd_owner_q == 1'b0) ? ram_rdata : rdata_q[0];
  assign m1.rdata = (rd_valid_q && rd_owner_q == 1'b1) ? ram_rdata : rdata_q[1];
  assign m0.rbusy = rbusy[0];
  assign m0.wbusy = wbusy[0];
  assign m1.rbusy = rbusy[1];
  assign m1.wbusy = wbusy[1];

  ap_one_pending: assert property (@(posedge clk) disable iff (!resetq)
    !(pend[0] && pend[1]));
  ap_no_strobe_while_pending: assert property (@(posedge clk) disable iff (!resetq)
    (strobe & pend) == '0);

endmodule

// File: tb/tb_spram_arbiter.sv
// Bench for spram_arbiter: reset, directed vector table, mid-operation reset,
// and a randomized run against a transaction-level reference model.
module tb_spram_arbiter;
  import spram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        resetq = 1'b0;
  logic        mem_load = 1'b0;
  logic [14:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [3:0]  ram_wen;
  logic [31:0] mem [0:255];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  spram_arbiter_if #(.AW(15), .DW(32)) m0_if ();
  spram_arbiter_if #(.AW(15), .DW(32)) m1_if ();

  spram_arbiter #(.AW(15), .DW(32)) dut (
    .clk       (clk),
    .resetq    (resetq),
    .m0        (m0_if),
    .m1        (m1_if),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_wen   (ram_wen),
    .ram_rdata (ram_rdata)
  );

  function automatic logic [31:0] init_pat(input int i);
    case (i)
      'h10:    return 32'hDEADBEEF;
      'h30:    return 32'hFFFFFFFF;
      'h40:    return 32'h12345678;
      default: return 32'hC0DE0000 | 32'(i);
    endcase
  endfunction

  // SPRAM behavioural model: byte-enabled write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_pat(i);
    end else begin
      for (int b = 0; b < 4; b++)
        if (ram_wen[b]) mem[ram_addr[7:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= mem[ram_addr[7:0]];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic [3:0] wm0, input logic [14:0] a0,
                       input logic [31:0] d0, input logic r1, input logic [3:0] wm1,
                       input logic [14:0] a1, input logic [31:0] d1);
    m0_if.rstrb = r0; m0_if.wmask = wm0; m0_if.addr = a0; m0_if.wdata = d0;
    m1_if.rstrb = r1; m1_if.wmask = wm1; m1_if.addr = a1; m1_if.wdata = d1;
  endtask

  task automatic idle();
    drive(1'b0, 4'h0, 15'h0, 32'h0, 1'b0, 4'h0, 15'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_busy(input string tag, input logic [3:0] exp);
    chk({tag, " busy{rb0,wb0,rb1,wb1}"},
        {28'h0, m0_if.rbusy, m0_if.wbusy, m1_if.rbusy, m1_if.wbusy}, {28'h0, exp});
  endtask

  typedef struct {
    logic        r0; logic [3:0] wm0; logic [14:0] a0; logic [31:0] d0;
    logic        r1; logic [3:0] wm1; logic [14:0] a1; logic [31:0] d1;
    logic [3:0]  e_wen;
    logic        e_addr_chk;
    logic [14:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_busy;   // {rb0,wb0,rb1,wb1}
    logic [31:0] e_rd0;
    logic [31:0] e_rd1;
  } vec_t;

  vec_t vecs [15];

  // Reference model state (transaction level).
  int          waiting;      // master whose request is waiting, -1 if none
  req_t        wreq;
  int          mlast;
  logic [31:0] mm [0:255];
  logic [31:0] exp_rd [2];

  initial begin : main
    req_t        nreq [2];
    logic        nv [2];
    int          served;
    req_t        sreq;
    logic [3:0]  eb;

    idle();
    // ---- reset with both strobes high ----
    resetq   = 1'b0;
    mem_load = 1'b1;
    drive(1'b1, 4'hF, 15'h10, 32'h1, 1'b1, 4'hF, 15'h20, 32'h2);
    step();
    mem_load = 1'b0;
    step();
    @(negedge clk);
    chk("reset ram_wen", {28'h0, ram_wen}, 32'h0);
    chk_busy("reset", 4'b0000);
    chk("reset m0_rdata", m0_if.rdata, 32'h0);
    chk("reset m1_rdata", m1_if.rdata, 32'h0);
    step();
    resetq = 1'b1;
    idle();

    // ---- directed vector table ----
    //             r0 wm0   a0     d0            r1 wm1   a1     d1            wen   ac a      wdata         busy     rd0           rd1
    vecs[0]  = '{1'b0, 4'hF, 15'h20, 32'h11223344, 1'b1, 4'h0, 15'h20, 32'h0,       4'hF, 1, 15'h20, 32'h11223344, 4'b0000, 32'h0,        32'h0};
    vecs[1]  = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 1, 15'h20, 32'h0,        4'b0010, 32'h0,        32'h0};
    vecs[2]  = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 0, 15'h0,  32'h0,        4'b0000, 32'h0,        32'h11223344};
    vecs[3]  = '{1'b1, 4'h0, 15'h10, 32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 1, 15'h10, 32'h0,        4'b0000, 32'h0,        32'h11223344};
    vecs[4]  = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 0, 15'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'h11223344};
    vecs[5]  = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h1, 15'h30, 32'h000000AB, 4'h1, 1, 15'h30, 32'h000000AB, 4'b0000, 32'hDEADBEEF, 32'h11223344};
    vecs[6]  = '{1'b1, 4'h0, 15'h30, 32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 1, 15'h30, 32'h0,        4'b0000, 32'hDEADBEEF, 32'h11223344};
    vecs[7]  = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 0, 15'h0,  32'h0,        4'b0000, 32'hFFFFFFAB, 32'h11223344};
    vecs[8]  = '{1'b1, 4'h0, 15'h10, 32'h0,        1'b1, 4'h0, 15'h30, 32'h0,       4'h0, 1, 15'h30, 32'h0,        4'b0000, 32'hFFFFFFAB, 32'h11223344};
    vecs[9]  = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 1, 15'h10, 32'h0,        4'b1000, 32'hFFFFFFAB, 32'hFFFFFFAB};
    vecs[10] = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 0, 15'h0,  32'h0,        4'b0000, 32'hDEADBEEF, 32'hFFFFFFAB};
    vecs[11] = '{1'b0, 4'hF, 15'h50, 32'hAAAA0000, 1'b0, 4'hF, 15'h50, 32'h0000BBBB, 4'hF, 1, 15'h50, 32'h0000BBBB, 4'b0000, 32'hDEADBEEF, 32'hFFFFFFAB};
    vecs[12] = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'hF, 1, 15'h50, 32'hAAAA0000, 4'b0100, 32'hDEADBEEF, 32'hFFFFFFAB};
    vecs[13] = '{1'b1, 4'h0, 15'h50, 32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 1, 15'h50, 32'h0,        4'b0000, 32'hDEADBEEF, 32'hFFFFFFAB};
    vecs[14] = '{1'b0, 4'h0, 15'h0,  32'h0,        1'b0, 4'h0, 15'h0,  32'h0,       4'h0, 0, 15'h0,  32'h0,        4'b0000, 32'hAAAA0000, 32'hFFFFFFAB};

    for (int v = 0; v < 15; v++) begin
      drive(vecs[v].r0, vecs[v].wm0, vecs[v].a0, vecs[v].d0,
            vecs[v].r1, vecs[v].wm1, vecs[v].a1, vecs[v].d1);
      @(negedge clk);
      chk($sformatf("vec%0d ram_wen", v), {28'h0, ram_wen}, {28'h0, vecs[v].e_wen});
      if (vecs[v].e_addr_chk)
        chk($sformatf("vec%0d ram_addr", v), {17'h0, ram_addr}, {17'h0, vecs[v].e_addr});
      if (vecs[v].e_wen != 4'h0)
        chk($sformatf("vec%0d ram_wdata", v), ram_wdata, vecs[v].e_wdata);
      chk_busy($sformatf("vec%0d", v), vecs[v].e_busy);
      chk($sformatf("vec%0d m0_rdata", v), m0_if.rdata, vecs[v].e_rd0);
      chk($sformatf("vec%0d m1_rdata", v), m1_if.rdata, vecs[v].e_rd1);
      step();
    end

    // ---- reset while m1 holds a pending write ----
    idle();
    drive(1'b0, 4'h0, 15'h0, 32'h0, 1'b1, 4'h0, 15'h10, 32'h0);  // m1 served alone -> last=1
    step();
    drive(1'b1, 4'h0, 15'h10, 32'h0, 1'b0, 4'hF, 15'h40, 32'h99999999);
    @(negedge clk);
    chk("midrst T ram_addr", {17'h0, ram_addr}, 32'h10);
    chk("midrst T ram_wen", {28'h0, ram_wen}, 32'h0);
    step();
    idle();
    resetq = 1'b0;
    @(negedge clk);
    chk("midrst T+1 m1_wbusy", {31'h0, m1_if.wbusy}, 32'h1);
    chk("midrst T+1 ram_wen", {28'h0, ram_wen}, 32'h0);
    step();
    resetq = 1'b1;
    @(negedge clk);
    chk_busy("midrst T+2", 4'b0000);
    chk("midrst T+2 ram_wen", {28'h0, ram_wen}, 32'h0);
    chk("midrst T+2 m0_rdata", m0_if.rdata, 32'h0);
    chk("midrst T+2 m1_rdata", m1_if.rdata, 32'h0);
    step();
    drive(1'b1, 4'h0, 15'h40, 32'h0, 1'b0, 4'h0, 15'h0, 32'h0);
    @(negedge clk);
    chk("midrst readback ram_addr", {17'h0, ram_addr}, 32'h40);
    step();
    idle();
    @(negedge clk);
    chk("midrst dropped write", m0_if.rdata, 32'h12345678);
    step();

    // ---- randomized traffic against the reference model ----
    resetq = 1'b0;
    step();
    resetq = 1'b1;
    waiting = -1;
    wreq    = '0;
    mlast   = 1;
    exp_rd[0] = 32'h0;
    exp_rd[1] = 32'h0;
    for (int i = 0; i < 256; i++) mm[i] = init_pat(i);

    for (int cyc = 0; cyc < 300; cyc++) begin
      // stimulus: a master only issues while it has nothing waiting
      for (int m = 0; m < 2; m++) begin
        nreq[m] = '0;
        nv[m]   = 1'b0;
        if (waiting != m && (cyc < 16 || $urandom_range(0, 1) == 1)) begin
          nv[m]          = 1'b1;
          nreq[m].addr   = 15'h80 + 15'($urandom_range(0, 15));
          nreq[m].wdata  = $urandom;
          nreq[m].is_read = ($urandom_range(0, 1) == 1);
          nreq[m].wmask  = nreq[m].is_read ? 4'h0 : 4'($urandom_range(1, 15));
        end
      end
      drive(nreq[0].is_read, nreq[0].wmask, nreq[0].addr, nreq[0].wdata,
            nreq[1].is_read, nreq[1].wmask, nreq[1].addr, nreq[1].wdata);

      // who gets the RAM this cycle: the waiting one, else round-robin among new
      served = -1;
      sreq   = '0;
      if (waiting >= 0) begin
        served = waiting;
        sreq   = wreq;
      end else if (nv[0] && nv[1]) begin
        served = 1 - mlast;
        sreq   = nreq[served];
      end else if (nv[0]) begin
        served = 0;
        sreq   = nreq[0];
      end else if (nv[1]) begin
        served = 1;
        sreq   = nreq[1];
      end
      eb = {waiting == 0 && wreq.is_read, waiting == 0 && !wreq.is_read,
            waiting == 1 && wreq.is_read, waiting == 1 && !wreq.is_read};

      @(negedge clk);
      chk_busy($sformatf("rnd%0d", cyc), eb);
      chk($sformatf("rnd%0d m0_rdata", cyc), m0_if.rdata, exp_rd[0]);
      chk($sformatf("rnd%0d m1_rdata", cyc), m1_if.rdata, exp_rd[1]);
      if (served < 0 || sreq.is_read) begin
        chk($sformatf("rnd%0d ram_wen", cyc), {28'h0, ram_wen}, 32'h0);
      end else begin
        chk($sformatf("rnd%0d ram_wen", cyc), {28'h0, ram_wen}, {28'h0, sreq.wmask});
        chk($sformatf("rnd%0d ram_wdata", cyc), ram_wdata, sreq.wdata);
      end
      if (served >= 0)
        chk($sformatf("rnd%0d ram_addr", cyc), {17'h0, ram_addr}, {17'h0, sreq.addr});

      // model update
      if (served >= 0) begin
        if (sreq.is_read) exp_rd[served] = mm[sreq.addr[7:0]];
        else
          for (int b = 0; b < 4; b++)
            if (sreq.wmask[b]) mm[sreq.addr[7:0]][8*b +: 8] = sreq.wdata[8*b +: 8];
        mlast = served;
      end
      if (waiting == served) waiting = -1;
      for (int m = 0; m < 2; m++)
        if (nv[m] && served != m) begin
          waiting = m;
          wreq    = nreq[m];
        end
      step();
    end

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1);
  end

endmodule
